// File: rtl/sdram_frame_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_frame_arbiter
//
// Frame-level arbiter for the single SDRAM read port of the capture frame
// buffer. Requester 0 (sensor_filter/shape_finder path) and requester 1
// (uart_watcher) are granted whole frames. Before every grant the SDRAM read
// address is rewound with a one-cycle clear pulse; during the grant the
// pixel req/vld handshake of the owner is forwarded. A grant that sees no
// read data for TIMEOUT cycles is aborted.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   policy               00 round-robin, 01 only req0, 10 only req1, 11 hold
//   sdram_ready_to_read  a complete frame is available in SDRAM
//   sdram_dout/_vld      read data and its one-per-pixel valid strobe
//   sdram_dout_req       pixel read request towards SDRAM (combinational)
//   sdram_clr_read_addr  one-cycle pulse, rewind SDRAM read address
//   reqN_frame           requester N wants a frame (level)
//   reqN_rd_req          requester N pixel request
//   reqN_en              requester N owns the port
//   reqN_ack             pixel valid to requester N (combinational)
//   reqN_din             pixel data, broadcast to both requesters
//   grant_id             last or current granted requester
//   busy                 arbiter is not idle
//   frame_done           one-cycle pulse, full frame delivered
//   timeout_err          one-cycle pulse, grant aborted on timeout
// ----------------------------------------------------------------------------
module sdram_frame_arbiter #(
    parameter int FRAME_PIXELS = 76800,
    parameter int PIX_W        = 16,
    parameter int CNT_W        = 17,
    parameter int TIMEOUT      = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       policy,
    input  logic             sdram_ready_to_read,
    input  logic [PIX_W-1:0] sdram_dout,
    input  logic             sdram_dout_vld,
    output logic             sdram_dout_req,
    output logic             sdram_clr_read_addr,
    input  logic             req0_frame,
    input  logic             req0_rd_req,
    output logic             req0_en,
    output logic             req0_ack,
    output logic [PIX_W-1:0] req0_din,
    input  logic             req1_frame,
    input  logic             req1_rd_req,
    output logic             req1_en,
    output logic             req1_ack,
    output logic [PIX_W-1:0] req1_din,
    output logic             grant_id,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN  = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_GRANT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              grant_id_q, grant_id_d;
    logic              last_served_q, last_served_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              en0_q, en0_d;
    logic              en1_q, en1_d;
    logic              clr_q, clr_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic              elig0_s, elig1_s, pick_s;
    logic              owner_rd_req_s, dout_req_s;

    // Policy filter and round-robin pick among eligible requesters.
    always_comb begin
        elig0_s = 1'b0;
        elig1_s = 1'b0;
        case (policy)
            2'b00: begin
                elig0_s = req0_frame;
                elig1_s = req1_frame;
            end
            2'b01: elig0_s = req0_frame;
            2'b10: elig1_s = req1_frame;
            default: begin
                elig0_s = 1'b0;
                elig1_s = 1'b0;
            end
        endcase
        // On a tie the requester that was not served last wins.
        if (elig0_s && elig1_s) begin
            pick_s = ~last_served_q;
        end else begin
            pick_s = elig1_s;
        end
    end

    // Owner's pixel request, gated once the whole frame has been requested.
    always_comb begin
        owner_rd_req_s = grant_id_q ? req1_rd_req : req0_rd_req;
        dout_req_s     = (state_q == S_GRANT) && owner_rd_req_s && (req_cnt_q < FRAME_LEN);
    end

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_served_d = last_served_q;
        pix_cnt_d     = pix_cnt_q;
        req_cnt_d     = req_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        en0_d         = en0_q;
        en1_d         = en1_q;
        busy_d        = busy_q;
        clr_d         = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sdram_ready_to_read && (elig0_s || elig1_s)) begin
                    state_d    = S_CLR;
                    grant_id_d = pick_s;
                    clr_d      = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_CLR: begin
                state_d   = S_GRANT;
                pix_cnt_d = '0;
                req_cnt_d = '0;
                tmo_cnt_d = '0;
                en0_d     = ~grant_id_q;
                en1_d     = grant_id_q;
            end
            S_GRANT: begin
                if (dout_req_s) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                end else begin
                    req_cnt_d = req_cnt_q;
                end
                if (sdram_dout_vld) begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    tmo_cnt_d = '0;
                    if (pix_cnt_q == FRAME_LAST) begin
                        state_d       = S_DONE;
                        en0_d         = 1'b0;
                        en1_d         = 1'b0;
                        frame_done_d  = 1'b1;
                        last_served_d = grant_id_q;
                    end else begin
                        state_d       = S_GRANT;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = S_IDLE;
                    en0_d         = 1'b0;
                    en1_d         = 1'b0;
                    busy_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    last_served_d = grant_id_q;
                end else begin
                    tmo_cnt_d     = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                en0_d   = 1'b0;
                en1_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            grant_id_q    <= 1'b0;
            last_served_q <= 1'b1;
            pix_cnt_q     <= '0;
            req_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            en0_q         <= 1'b0;
            en1_q         <= 1'b0;
            clr_q         <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_served_q <= last_served_d;
            pix_cnt_q     <= pix_cnt_d;
            req_cnt_q     <= req_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            en0_q         <= en0_d;
            en1_q         <= en1_d;
            clr_q         <= clr_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sdram_dout_req      = dout_req_s;
    assign sdram_clr_read_addr = clr_q;
    assign req0_en             = en0_q;
    assign req1_en             = en1_q;
    // en is high exactly while granted, so it also gates the ack.
    assign req0_ack            = en0_q & sdram_dout_vld;
    assign req1_ack            = en1_q & sdram_dout_vld;
    assign req0_din            = sdram_dout;
    assign req1_din            = sdram_dout;
    assign grant_id            = grant_id_q;
    assign busy                = busy_q;
    assign frame_done          = frame_done_q;
    assign timeout_err         = timeout_err_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdram_frame_arbiter
//
// Randomized bench for sdram_frame_arbiter. The bench plays the SDRAM: it
// counts issued pixel requests and returns read data with random gaps. The
// reference model works per frame: who should be granted (policy plus
// last-served), how many requests may still be issued, how many pixels have
// arrived and how long the data has been silent.
// ----------------------------------------------------------------------------
module tb_sdram_frame_arbiter;

    localparam int FP  = 160;
    localparam int TMO = 50;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    policy;
    logic          ready;
    logic [PW-1:0] dout;
    logic          vld;
    logic          dreq, clr;
    logic          f0, f1, rr0, rr1;
    logic          en0, en1, ack0, ack1;
    logic [PW-1:0] din0, din1;
    logic          gid, busy, fdone, terr;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_served;

    always #5 clk = ~clk;

    sdram_frame_arbiter #(
        .FRAME_PIXELS(FP),
        .PIX_W       (PW),
        .CNT_W       (17),
        .TIMEOUT     (TMO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .policy              (policy),
        .sdram_ready_to_read (ready),
        .sdram_dout          (dout),
        .sdram_dout_vld      (vld),
        .sdram_dout_req      (dreq),
        .sdram_clr_read_addr (clr),
        .req0_frame          (f0),
        .req0_rd_req         (rr0),
        .req0_en             (en0),
        .req0_ack            (ack0),
        .req0_din            (din0),
        .req1_frame          (f1),
        .req1_rd_req         (rr1),
        .req1_en             (en1),
        .req1_ack            (ack1),
        .req1_din            (din1),
        .grant_id            (gid),
        .busy                (busy),
        .frame_done          (fdone),
        .timeout_err         (terr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected winner from the current policy, frame levels and last served.
    function automatic logic exp_pick();
        logic e0, e1;
        e0 = f0 && (policy == 2'b00 || policy == 2'b01);
        e1 = f1 && (policy == 2'b00 || policy == 2'b10);
        return (e0 && e1) ? ~last_served : e1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, {dreq, clr, en0, en1, ack0, ack1, gid, busy, fdone, terr}, 0);
        chk({tag, "_din"}, {din0, din1}, 0);
    endtask

    task automatic wait_grant(input logic exp_id);
        int guard = 0;
        rr0 = 1'b0;
        rr1 = 1'b0;
        while (clr !== 1'b1 && guard < 8) begin
            vld  = 1'($urandom_range(0, 1));
            dout = PW'($urandom);
            #1;
            chk("idle_ack", {ack1, ack0}, 0);
            chk("idle_req", dreq, 0);
            tick();
            guard++;
        end
        chk("clr_seen", clr, 1);
        chk("grant_id", gid, exp_id);
        chk("busy_clr", busy, 1);
        chk("en_in_clr", {en1, en0}, 0);
        // Data strobe during the clear cycle must be dropped.
        vld = 1'b1;
        #1;
        chk("clr_ack", {ack1, ack0}, 0);
        chk("clr_req", dreq, 0);
        tick();
        vld = 1'b0;
        chk("clr_len", clr, 0);
        chk("en_grant", {en1, en0}, exp_id ? 2'b10 : 2'b01);
    endtask

    // One grant: full frame, stall into timeout (abort_at>=0, !abort_rst)
    // or reset once abort_at pixels have arrived (abort_rst).
    task automatic run_frame(input logic exp_id, input int abort_at, input logic abort_rst,
                             input logic [1:0] mid_policy, input logic mid_drop);
        int   pixels = 0;
        int   issued = 0;
        int   outst  = 0;
        int   idle   = 0;
        int   guard  = 0;
        logic done   = 1'b0;
        logic rg, ro, er;
        logic [1:0] en_exp;
        en_exp = exp_id ? 2'b10 : 2'b01;
        wait_grant(exp_id);
        while (!done && guard < 4000) begin
            guard++;
            if (pixels == FP / 2) begin
                policy = mid_policy;
                if (mid_drop) begin
                    f0 = 1'b0;
                    f1 = 1'b0;
                end
            end
            if (abort_rst && pixels == abort_at) begin
                vld  = 1'b0;
                dout = '0;
                rr0  = 1'b0;
                rr1  = 1'b0;
                rst  = 1'b0;
                #1;
                chk_all_zero("rst_mid_grant");
                last_served = 1'b1;
                done = 1'b1;
            end else begin
                rg = (idle >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                ro = 1'($urandom_range(0, 1));
                if (outst > 0 && !(abort_at >= 0 && pixels >= abort_at))
                    vld = (idle >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                else
                    vld = 1'b0;
                dout = PW'($urandom);
                rr0  = exp_id ? ro : rg;
                rr1  = exp_id ? rg : ro;
                #1;
                er = rg && (issued < FP);
                chk("dout_req", dreq, er);
                chk("ack_owner", exp_id ? ack1 : ack0, vld);
                chk("ack_other", exp_id ? ack0 : ack1, 0);
                chk("din_bcast", {din0, din1}, {dout, dout});
                tick();
                if (er) begin
                    issued++;
                    outst++;
                end
                if (vld) begin
                    outst--;
                    pixels++;
                    idle = 0;
                end else begin
                    idle++;
                end
                if (pixels == FP) begin
                    chk("frame_done", fdone, 1);
                    chk("en_done", {en1, en0}, 0);
                    chk("busy_done", busy, 1);
                    chk("terr_done", terr, 0);
                    last_served = exp_id;
                    done = 1'b1;
                    vld = 1'b0;
                    rr0 = 1'b0;
                    rr1 = 1'b0;
                    tick();
                    chk("done_len", fdone, 0);
                    chk("busy_after", busy, 0);
                end else if (idle == TMO) begin
                    chk("timeout_err", terr, 1);
                    chk("en_tmo", {en1, en0}, 0);
                    chk("busy_tmo", busy, 0);
                    chk("fdone_tmo", fdone, 0);
                    last_served = exp_id;
                    done = 1'b1;
                    vld = 1'b0;
                    rr0 = 1'b0;
                    rr1 = 1'b0;
                    tick();
                    chk("tmo_len", terr, 0);
                end else begin
                    chk("en_hold", {en1, en0}, en_exp);
                    chk("fdone_early", fdone, 0);
                    chk("terr_early", terr, 0);
                end
            end
        end
        chk("frame_finished", done, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; policy = 2'b00; ready = 1'b0; dout = '0; vld = 1'b0;
        f0 = 1'b0; f1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        last_served = 1'b1;
        #1;
        chk_all_zero("reset");
        repeat (3) tick();
        rst = 1'b1;

        // No frame available: no grant.
        f0 = 1'b1;
        repeat (4) tick();
        chk("no_ready_busy", busy, 0);
        chk("no_ready_clr", clr, 0);

        // Single requester 0.
        ready = 1'b1;
        run_frame(1'b0, -1, 1'b0, 2'b00, 1'b0);

        // Both requesting, round-robin over three frames.
        f1 = 1'b1;
        repeat (3) run_frame(exp_pick(), -1, 1'b0, 2'b00, 1'b0);

        // Hold policy: no new grants.
        policy = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_busy", busy, 0);
        end

        // Only req1; policy flips and frames drop mid-grant, frame completes.
        policy = 2'b10;
        run_frame(exp_pick(), -1, 1'b0, 2'b01, 1'b1);
        f0 = 1'b1;
        f1 = 1'b1;
        run_frame(exp_pick(), -1, 1'b0, 2'b01, 1'b0);

        // Stall after 100 pixels -> timeout, then the other requester.
        policy = 2'b00;
        run_frame(exp_pick(), 100, 1'b0, 2'b00, 1'b0);
        run_frame(exp_pick(), -1, 1'b0, 2'b00, 1'b0);

        // Reset in the middle of a grant, then a clean full frame.
        run_frame(exp_pick(), 37, 1'b1, 2'b00, 1'b0);
        repeat (2) tick();
        chk_all_zero("rst_held");
        rst = 1'b1;
        run_frame(exp_pick(), -1, 1'b0, 2'b00, 1'b0);

        ready = 1'b0;
        repeat (4) tick();
        chk("end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
